// File: rtl/mlab_fifo_pkg.sv
// mlab_fifo_pkg
//   Shared definitions for the MLAB-based FIFO: default geometry, the
//   depth and count-width helpers, and the even-parity function used by
//   the optional parity column (macro MLAB_FIFO_PARITY_EN).
package mlab_fifo_pkg;

   localparam int DEF_WIDTH      = 20;
   localparam int DEF_ADDR_WIDTH = 5;

   // One extra count bit lets a count of DEPTH be told apart from 0.
   localparam int CNT_EXTRA_BITS = 1;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic int cnt_width(input int addr_width);
      return addr_width + CNT_EXTRA_BITS;
   endfunction

   // Even parity: the returned bit makes the total number of ones even.
   function automatic logic even_parity(input logic [63:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/mlab_fifo_ram.sv
// mlab_fifo_ram
//   Behavioural model of a WIDTH-column MLAB array: registered write port,
//   asynchronous read port. Used for simulation and inferred as MLAB.
//   Ports:
//     wclk       write clock
//     wena       write enable (sampled at wclk)
//     waddr_reg  write address (already registered by the caller)
//     wdata_reg  write data    (already registered by the caller)
//     raddr      read address, combinational
//     rdata      read data, combinational from raddr
module mlab_fifo_ram
   import mlab_fifo_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  wclk,
   input  logic                  wena,
   input  logic [ADDR_WIDTH-1:0] waddr_reg,
   input  logic [WIDTH-1:0]      wdata_reg,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage arrays get no reset; a reset would prevent mapping onto
   // MLAB cells, and the FIFO pointers already define which entries are live.
   always_ff @(posedge wclk) begin
      if (wena) begin
         mem[waddr_reg] <= wdata_reg;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mlab_fifo.sv
// mlab_fifo
//   Single-clock show-ahead FIFO on MLAB storage with valid/ready handshake
//   on both sides. Write path: accept -> write-stage register -> MLAB cell
//   one edge later. Read path: async MLAB read at rptr feeds a registered
//   output stage. Empty-FIFO latency is two edges from accept to dout_valid.
//   Optional: `define MLAB_FIFO_PARITY_EN adds an even-parity column,
//   rechecked on each output load; mismatches set sticky parity_err.
//   Ports:
//     clk         clock
//     sclr        synchronous active-high reset
//     din         write data
//     din_valid   write request
//     din_ready   room available (used_words < DEPTH)
//     dout        registered head word
//     dout_valid  head word present
//     dout_ready  consumer takes the head word
//     used_words  words held (write stage + RAM + output register)
//     parity_err  sticky parity error (0 when parity is not built)
module mlab_fifo
   import mlab_fifo_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  sclr,
   input  logic [WIDTH-1:0]      din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [WIDTH-1:0]      dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [ADDR_WIDTH:0]   used_words,
   output logic                  parity_err
);

   localparam int CNT_W = cnt_width(ADDR_WIDTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth_of(ADDR_WIDTH));

`ifdef MLAB_FIFO_PARITY_EN
   localparam int RAM_W = WIDTH + 1;
`else
   localparam int RAM_W = WIDTH;
`endif

   logic [ADDR_WIDTH-1:0] wptr_q,  wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q,  rptr_d;
   logic                  wvalid_q, wvalid_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [RAM_W-1:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;    // committed words in the RAM
   logic [CNT_W-1:0]      used_q,  used_d;
   logic [WIDTH-1:0]      dout_q,  dout_d;
   logic                  dval_q,  dval_d;
   logic [RAM_W-1:0]      rdata;

   logic wr_acc;
   logic rd_acc;
   logic load;

   assign din_ready = (used_q != DEPTH_C);
   assign wr_acc    = din_valid & din_ready;
   assign rd_acc    = dval_q & dout_ready;
   // Only committed words are read, so the read address never collides
   // with the pending write address.
   assign load      = (!dval_q || dout_ready) && (cnt_q != '0);

`ifdef MLAB_FIFO_PARITY_EN
   logic pchk_q, pchk_d;   // mismatch seen on the load just made
   logic perr_q, perr_d;
`endif

   // NOTE: every signal driven here is given a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      dout_d   = dout_q;
      dval_d   = dval_q;
      wvalid_d = wr_acc;

      if (wr_acc) begin
         waddr_d = wptr_q;
         wptr_d  = wptr_q + 1'b1;
`ifdef MLAB_FIFO_PARITY_EN
         wdata_d = {even_parity(64'(din)), din};
`else
         wdata_d = din;
`endif
      end

      if (load) begin
         dout_d = rdata[WIDTH-1:0];
         dval_d = 1'b1;
         rptr_d = rptr_q + 1'b1;
      end else if (rd_acc) begin
         dval_d = 1'b0;
      end

      // The write stage commits one word per edge; each load consumes one.
      cnt_d  = cnt_q + {{ADDR_WIDTH{1'b0}}, wvalid_q} - {{ADDR_WIDTH{1'b0}}, load};
      used_d = used_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};

`ifdef MLAB_FIFO_PARITY_EN
      pchk_d = load && (even_parity(64'(rdata[WIDTH-1:0])) != rdata[WIDTH]);
      perr_d = perr_q | pchk_q;
`endif
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (sclr) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         wvalid_q <= 1'b0;
         cnt_q    <= '0;
         used_q   <= '0;
         dout_q   <= '0;
         dval_q   <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         wvalid_q <= wvalid_d;
         cnt_q    <= cnt_d;
         used_q   <= used_d;
         dout_q   <= dout_d;
         dval_q   <= dval_d;
      end
      // Write-stage data is qualified by wvalid_q and needs no reset.
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
   end

`ifdef MLAB_FIFO_PARITY_EN
   always_ff @(posedge clk) begin
      if (sclr) begin
         pchk_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         pchk_q <= pchk_d;
         perr_q <= perr_d;
      end
   end
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   mlab_fifo_ram #(
      .WIDTH      (RAM_W),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .wclk      (clk),
      .wena      (wvalid_q),
      .waddr_reg (waddr_q),
      .wdata_reg (wdata_q),
      .raddr     (rptr_q),
      .rdata     (rdata)
   );

   assign dout       = dout_q;
   assign dout_valid = dval_q;
   assign used_words = used_q;

endmodule

// File: tb/tb_mlab_fifo.sv
// tb_mlab_fifo
//   Scoreboard bench for mlab_fifo (WIDTH 20, ADDR_WIDTH 5). The driver
//   pushes every accepted word into a queue; an independent monitor pops
//   and compares on each accepted read, and tracks occupancy from the
//   handshakes to check used_words, din_ready, empty and hold behaviour.
module tb_mlab_fifo;

   localparam int W     = 20;
   localparam int AW    = 5;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          sclr;
   logic [W-1:0]  din;
   logic          din_valid;
   logic          din_ready;
   logic [W-1:0]  dout;
   logic          dout_valid;
   logic          dout_ready;
   logic [AW:0]   used_words;
   logic          parity_err;

   mlab_fifo #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .sclr       (sclr),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .used_words (used_words),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] sb[$];
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle at the falling edge; record the word if it will be accepted.
   task automatic step(input logic v, input logic [W-1:0] d, input logic rdy);
      @(negedge clk);
      din_valid  = v;
      din        = d;
      dout_ready = rdy;
      #1;
      if (v && din_ready) sb.push_back(d);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && used_words != 0; i++) step(1'b0, '0, 1'b1);
      check("drain_empty", 64'(used_words), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      sclr = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
      @(negedge clk);
      sclr = 1'b0;
      #1;
      check("rst_din_ready",  64'(din_ready),  64'd1);
      check("rst_dout_valid", 64'(dout_valid), 64'd0);
      check("rst_used",       64'(used_words), 64'd0);
      check("rst_dout",       64'(dout),       64'd0);
   endtask

   // Monitor: occupancy model plus scoreboard pop on every accepted read.
   initial begin
      int           mcount = 0;
      logic         prev_hold = 1'b0;
      logic         prev_sclr = 1'b0;
      logic [W-1:0] prev_dout = '0;
      logic [W-1:0] exp_w;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            if (prev_sclr) begin
               check("mon_rst_dout_valid", 64'(dout_valid), 64'd0);
               check("mon_rst_dout",       64'(dout),       64'd0);
            end
            if (!sclr) begin
               check("mon_used",      64'(used_words), 64'(mcount));
               check("mon_din_ready", 64'(din_ready),  64'(mcount < DEPTH));
               if (mcount == 0) check("mon_empty_valid", 64'(dout_valid), 64'd0);
               if (prev_hold) begin
                  check("mon_hold_valid", 64'(dout_valid), 64'd1);
                  check("mon_hold_dout",  64'(dout),       64'(prev_dout));
               end
`ifndef MLAB_FIFO_PARITY_EN
               check("mon_parity_off", 64'(parity_err), 64'd0);
`endif
               if (dout_valid && dout_ready) begin
                  if (sb.size() == 0) begin
                     check("mon_unexpected_out", 64'(dout), 64'hDEAD_BEEF);
                  end else begin
                     exp_w = sb.pop_front();
                     check("mon_data", 64'(dout), 64'(exp_w));
                  end
               end
               mcount = mcount + int'(din_valid && din_ready) - int'(dout_valid && dout_ready);
            end else begin
               mcount = 0;
               sb.delete();
            end
            prev_hold = dout_valid && !dout_ready && !sclr;
            prev_dout = dout;
            prev_sclr = sclr;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first, last, nout, s;
      sclr = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      do_reset();

      // Single word: latency and hold.
      step(1'b1, 20'h12345, 1'b0);               // accepted at edge 0
      step(1'b0, '0, 1'b0);
      check("lat_e0_valid", 64'(dout_valid), 64'd0);
      step(1'b0, '0, 1'b0);
      check("lat_e1_valid", 64'(dout_valid), 64'd0);
      step(1'b0, '0, 1'b0);
      check("lat_e2_valid", 64'(dout_valid), 64'd1);
      check("lat_e2_dout",  64'(dout),       64'h12345);
      check("lat_e2_used",  64'(used_words), 64'd1);
      repeat (5) step(1'b0, '0, 1'b0);
      check("hold_dout", 64'(dout), 64'h12345);
      drain();

      // Fill to full, then a rejected write, then drain in order.
      for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i), 1'b0);
      step(1'b1, 20'hFFFFF, 1'b0);
      check("full_din_ready", 64'(din_ready),  64'd0);
      check("full_used",      64'(used_words), 64'(DEPTH));
      repeat (4) step(1'b1, 20'hFFFFF, 1'b0);
      check("full_used_hold", 64'(used_words), 64'(DEPTH));
      drain();

      // Continuous streaming, 100 words through wrapping pointers.
      first = -1; last = -1; nout = 0; s = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, W'(i + 16'h100), 1'b1);
         if (dout_valid) begin if (first < 0) first = s; last = s; nout++; end
         check("stream_used_le3", 64'(used_words <= 3), 64'd1);
         s++;
      end
      for (int i = 0; i < 20 && used_words != 0; i++) begin
         step(1'b0, '0, 1'b1);
         if (dout_valid) begin if (first < 0) first = s; last = s; nout++; end
         s++;
      end
      check("stream_first_latency", 64'(first), 64'd3);
      check("stream_count",         64'(nout),  64'd100);
      check("stream_one_per_cycle", 64'(last - first), 64'd99);

      // Random traffic around the full boundary.
      for (int i = 0; i < DEPTH; i++) step(1'b1, W'($urandom), 1'b0);
      for (int i = 0; i < 300; i++) begin
         step(1'b1, W'($urandom), 1'($urandom_range(0, 1)));
         check("rand_used_le_depth", 64'(used_words <= DEPTH), 64'd1);
      end
      drain();

      // Reset with 10 words held, then a fresh word comes out first.
      for (int i = 0; i < 10; i++) step(1'b1, W'(i + 20'h500), 1'b0);
      step(1'b0, '0, 1'b0);
      check("mid_used_10", 64'(used_words), 64'd10);
      do_reset();
      step(1'b1, 20'hABCDE, 1'b0);
      for (int i = 0; i < 10 && !dout_valid; i++) step(1'b0, '0, 1'b0);
      check("post_rst_first", 64'(dout), 64'hABCDE);
      drain();

`ifdef MLAB_FIFO_PARITY_EN
      check("par_clean", 64'(parity_err), 64'd0);
      do_reset();
      step(1'b1, 20'h00011, 1'b0);
      step(1'b1, 20'h00022, 1'b0);
      repeat (4) step(1'b0, '0, 1'b0);
      // Second word sits committed at address 1; corrupt one data bit.
      dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
      sb[1] = sb[1] ^ 20'h1;
      step(1'b0, '0, 1'b1);                     // read first, load corrupted word
      step(1'b0, '0, 1'b0);
      check("par_not_yet", 64'(parity_err), 64'd0);
      step(1'b0, '0, 1'b0);
      check("par_set", 64'(parity_err), 64'd1);
      drain();
      repeat (3) step(1'b0, '0, 1'b0);
      check("par_sticky", 64'(parity_err), 64'd1);
      do_reset();
      check("par_cleared", 64'(parity_err), 64'd0);
`endif

      repeat (3) step(1'b0, '0, 1'b0);
      check("sb_empty_at_end", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
